sevenseg_hex_counter: RTL and testbench

Upstream stage of the seven-segment decoder: a hex digit source that produces the 4-bit value driven onto the decoder's nibble input.
Counts 0x0-0xF up or down in either of two ways: a debounced push-button step, or a prescaled free-running tick. Supports a synchronous parallel load and emits a one-cycle wrap pulse so digits can be cascaded.

---
 rtl/sevenseg_hex_counter.sv | 135 +++++++++++++
 tb/tb_sevenseg_hex_counter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_hex_counter.sv
// Hex digit source for the seven-segment decoder: a debounced push-button step
// or a prescaled auto-tick advances the digit up or down, with parallel load and a wrap pulse.
module sevenseg_hex_counter #(
  parameter int PRESCALE_W      = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_step,
  input  logic       dir,
  input  logic       run,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       wrap
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PRESCALE_W-1:0] PRESC_ONE  = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] PRESC_MAX  = '1;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } deb_state_t;

  logic [1:0]            sync_reg;
  deb_state_t            state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  step_pulse_reg;
  logic [PRESCALE_W-1:0] presc_reg;
  logic [3:0]            digit_reg;
  logic                  wrap_reg;

  logic s;
  logic tick;
  logic advance;

  // Two-flop synchronizer; sync_reg[1] is the only view of the raw button.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], btn_step};
    end
  end

  assign s = sync_reg[1];

  // Debounce: a level change is accepted only after DEBOUNCE_CYCLES equal samples;
  // only an accepted rising level emits a step, so a held button never repeats.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg      <= S_LOW;
      cnt_reg        <= '0;
      step_pulse_reg <= 1'b0;
    end else begin
      step_pulse_reg <= 1'b0;
      case (state_reg)
        S_LOW: begin
          if (s) begin
            state_reg <= S_RISE;
            cnt_reg   <= CNT_ONE;
          end
        end
        S_RISE: begin
          if (!s) begin
            state_reg <= S_LOW;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg      <= S_HIGH;
            step_pulse_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!s) begin
            state_reg <= S_FALL;
            cnt_reg   <= CNT_ONE;
          end
        end
        S_FALL: begin
          if (s) begin
            state_reg <= S_HIGH;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= S_LOW;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        default: begin
          state_reg <= S_LOW;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign tick    = run && (presc_reg == PRESC_MAX);
  assign advance = step_pulse_reg || tick;

  // Load wins over any advance and restarts the prescaler phase.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      presc_reg <= '0;
      digit_reg <= 4'h0;
      wrap_reg  <= 1'b0;
    end else if (load) begin
      presc_reg <= '0;
      digit_reg <= load_val;
      wrap_reg  <= 1'b0;
    end else begin
      presc_reg <= run ? (presc_reg + PRESC_ONE) : '0;
      if (advance) begin
        if (dir) begin
          digit_reg <= digit_reg + 4'd1;
          wrap_reg  <= (digit_reg == 4'hF);
        end else begin
          digit_reg <= digit_reg - 4'd1;
          wrap_reg  <= (digit_reg == 4'h0);
        end
      end else begin
        wrap_reg <= 1'b0;
      end
    end
  end

  assign digit = digit_reg;
  assign wrap  = wrap_reg;

endmodule

// File: tb/tb_sevenseg_hex_counter.sv
// Self-checking bench for sevenseg_hex_counter: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a behavioural model.
module tb_sevenseg_hex_counter;

  localparam int PW  = 2;
  localparam int DEB = 4;
  localparam int PERIOD = 1 << PW;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       btn_step;
  logic       dir;
  logic       run;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] digit;
  logic       wrap;

  int total = 0;
  int bad   = 0;
  bit check_en = 0;

  sevenseg_hex_counter #(.PRESCALE_W(PW), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .btn_step (btn_step),
    .dir      (dir),
    .run      (run),
    .load     (load),
    .load_val (load_val),
    .digit    (digit),
    .wrap     (wrap)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the button is accepted once the synchronized level has
  // differed from the accepted level for DEB consecutive samples.
  int m_digit, m_wrap, m_presc, m_sync1, m_sync2, m_acc, m_run_len, m_pulse;

  always @(posedge clock) begin
    int adv, new_pulse;
    if (!reset_n) begin
      m_digit = 0; m_wrap = 0; m_presc = 0;
      m_sync1 = 0; m_sync2 = 0; m_acc = 0; m_run_len = 0; m_pulse = 0;
    end else begin
      adv = (m_pulse != 0 || (run && m_presc == PERIOD - 1)) ? 1 : 0;
      new_pulse = 0;
      if (m_sync2 != m_acc) begin
        m_run_len++;
        if (m_run_len == DEB) begin
          m_acc = m_sync2;
          m_run_len = 0;
          new_pulse = m_sync2;
        end
      end else begin
        m_run_len = 0;
      end
      if (load) begin
        m_digit = load_val;
        m_wrap = 0;
        m_presc = 0;
      end else begin
        m_presc = run ? (m_presc + 1) % PERIOD : 0;
        if (adv != 0) begin
          m_wrap = dir ? (m_digit == 15) : (m_digit == 0);
          m_digit = dir ? (m_digit + 1) % 16 : (m_digit + 15) % 16;
        end else begin
          m_wrap = 0;
        end
      end
      m_pulse = new_pulse;
      m_sync2 = m_sync1;
      m_sync1 = btn_step;
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      chk("model_digit", 32'(digit), 32'(m_digit));
      chk("model_wrap", 32'(wrap), 32'(m_wrap));
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0; btn_step = 1'b1; run = 1'b1; dir = 1'b1; load = 1'b0; load_val = 4'h0;

    // Reset held with button and run active
    for (int i = 0; i < 3; i++) begin
      wait_n(1);
      check_en = 1;
      chk("rst_digit", 32'(digit), 32'h0);
      chk("rst_wrap", 32'(wrap), 32'h0);
    end
    reset_n = 1'b1; run = 1'b0;
    wait_n(6);
    chk("rst_held_e6", 32'(digit), 32'h0);
    wait_n(1);
    chk("rst_held_e7", 32'(digit), 32'h1);
    $display("txn reset_release_held digit=%0h", digit);

    // Long hold gives no repeat, then a short glitch is rejected
    wait_n(20);
    chk("hold_norepeat", 32'(digit), 32'h1);
    btn_step = 1'b0;
    wait_n(10);
    btn_step = 1'b1;
    wait_n(3);
    btn_step = 1'b0;
    wait_n(10);
    chk("glitch_reject", 32'(digit), 32'h1);
    $display("txn glitch digit=%0h", digit);

    // Auto-count from 0xE
    load = 1'b1; load_val = 4'hE; run = 1'b1; dir = 1'b1;
    wait_n(1);
    chk("auto_load", 32'(digit), 32'hE);
    load = 1'b0;
    wait_n(3);
    chk("auto_e3", 32'(digit), 32'hE);
    wait_n(1);
    chk("auto_e4", 32'(digit), 32'hF);
    wait_n(3);
    chk("auto_e7", 32'(digit), 32'hF);
    wait_n(1);
    chk("auto_wrap_digit", 32'(digit), 32'h0);
    chk("auto_wrap_pulse", 32'(wrap), 32'h1);
    wait_n(1);
    chk("auto_wrap_clear", 32'(wrap), 32'h0);
    run = 1'b0;
    wait_n(5);
    chk("auto_hold", 32'(digit), 32'h0);
    run = 1'b1;
    wait_n(3);
    chk("auto_restart3", 32'(digit), 32'h0);
    wait_n(1);
    chk("auto_restart4", 32'(digit), 32'h1);
    run = 1'b0;
    $display("txn autocount digit=%0h", digit);

    // Down wrap from a button press
    load = 1'b1; load_val = 4'h0; dir = 1'b0;
    wait_n(1);
    load = 1'b0; btn_step = 1'b1;
    wait_n(6);
    chk("down_e6", 32'(digit), 32'h0);
    wait_n(1);
    chk("down_digit", 32'(digit), 32'hF);
    chk("down_wrap", 32'(wrap), 32'h1);
    wait_n(1);
    chk("down_wrap_clear", 32'(wrap), 32'h0);
    btn_step = 1'b0;
    wait_n(10);
    $display("txn down_wrap digit=%0h", digit);

    // Step and tick coincide: single advance
    btn_step = 1'b1; dir = 1'b1;
    wait_n(2);
    load = 1'b1; load_val = 4'h5; run = 1'b1;
    wait_n(1);
    load = 1'b0;
    wait_n(3);
    chk("coinc_e6", 32'(digit), 32'h5);
    wait_n(1);
    chk("coinc_single", 32'(digit), 32'h6);
    btn_step = 1'b0; run = 1'b0;
    wait_n(10);
    $display("txn coincident digit=%0h", digit);

    // Load beats a coincident step and tick, and restarts the prescaler
    btn_step = 1'b1;
    wait_n(2);
    load = 1'b1; load_val = 4'h5; run = 1'b1;
    wait_n(1);
    load = 1'b0;
    wait_n(3);
    load = 1'b1; load_val = 4'hA;
    wait_n(1);
    load = 1'b0;
    chk("prio_digit", 32'(digit), 32'hA);
    chk("prio_wrap", 32'(wrap), 32'h0);
    wait_n(3);
    chk("prio_presc3", 32'(digit), 32'hA);
    wait_n(1);
    chk("prio_presc4", 32'(digit), 32'hB);
    btn_step = 1'b0; run = 1'b0;
    wait_n(10);
    $display("txn load_priority digit=%0h", digit);

    // Reset in the middle of a press
    btn_step = 1'b1;
    wait_n(3);
    reset_n = 1'b0; btn_step = 1'b0;
    wait_n(2);
    reset_n = 1'b1;
    wait_n(15);
    chk("midpress_reset", 32'(digit), 32'h0);
    $display("txn reset_midpress digit=%0h", digit);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) btn_step = ~btn_step;
      dir = 1'($urandom_range(1));
      if ($urandom_range(19) == 0) run = ~run;
      load = ($urandom_range(24) == 0);
      load_val = 4'($urandom_range(15));
      reset_n = ($urandom_range(299) != 0);
      wait_n(1);
    end
    reset_n = 1'b1; load = 1'b0;
    wait_n(2);
    $display("txn random_done digit=%0h", digit);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
